// File: rtl/vga_vram_reader_if.sv
// ---------------------------------------------------------------------------
// vga_vram_reader_if
// Display-side VRAM read port shared between the VGA reader and the memory
// subsystem.
//   gpu_address : 32-bit read address, driven by the reader (registered)
//   vram_out    : 8-bit greyscale pixel returned for gpu_address after a
//                 fixed read latency, driven by the memory
// Handshake: there is no valid/ready pair. The reader issues one address per
// pixel clock and the memory returns the byte a fixed number of cycles later,
// so the reader aligns everything else to that latency.
// ---------------------------------------------------------------------------
interface vga_vram_reader_if;
    logic [31:0] gpu_address;
    logic [7:0]  vram_out;

    modport master (
        output gpu_address,
        input  vram_out
    );

    modport slave (
        input  gpu_address,
        output vram_out
    );
endinterface

// File: rtl/vga_vram_reader.sv
// ---------------------------------------------------------------------------
// vga_vram_reader
// Generates VGA timing (640x480@60 by default), reads an IMG_W x IMG_H
// greyscale image from VRAM placed at (X0,Y0) and drives RGB/sync for a DAC.
// Ports:
//   clk, rst     : pixel clock, asynchronous active-high reset
//   enable       : low forces RGB to black; timing keeps running
//   vram         : VRAM read port (gpu_address out, vram_out in)
//   hsync, vsync : active-low syncs
//   blank_n      : high in the visible area
//   sync_n       : tied 0
//   r, g, b      : greyscale pixel, r=g=b
//   frame_start  : one-cycle pulse on output pixel (0,0)
// All outputs lag the counters by READ_LATENCY+2 cycles: one cycle for the
// address register, READ_LATENCY for the memory and one for the pixel register.
// ---------------------------------------------------------------------------
module vga_vram_reader #(
    parameter int          H_VISIBLE    = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_VISIBLE    = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter int          IMG_W        = 256,
    parameter int          IMG_H        = 256,
    parameter int          X0           = 192,
    parameter int          Y0           = 112,
    parameter logic [31:0] ADDR_BASE    = 32'd0,
    parameter int          READ_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    vga_vram_reader_if.master         vram,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      blank_n,
    output logic                      sync_n,
    output logic [7:0]                r,
    output logic [7:0]                g,
    output logic [7:0]                b,
    output logic                      frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int PIPE    = READ_LATENCY + 2;
    localparam int OFF_W   = $clog2(IMG_W * IMG_H);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] X_BEG  = 10'(X0);
    localparam logic [9:0] X_END  = 10'(X0 + IMG_W);
    localparam logic [9:0] Y_BEG  = 10'(Y0);
    localparam logic [9:0] Y_END  = 10'(Y0 + IMG_H);

    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(IMG_W * IMG_H - 1);

    if (X0 + IMG_W > H_VISIBLE || Y0 + IMG_H > V_VISIBLE) begin : g_bad_window
        $error("vga_vram_reader: image window exceeds the visible area");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_vram_reader: frame totals do not fit 10-bit counters");
    end

    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic [OFF_W-1:0] offset_q, offset_d;
    logic [OFF_W-1:0] off_cur;
    logic [31:0]      addr_q, addr_d;
    logic [PIPE-1:0]  hs_pipe_q, hs_pipe_d;
    logic [PIPE-1:0]  vs_pipe_q, vs_pipe_d;
    logic [PIPE-1:0]  vis_pipe_q, vis_pipe_d;
    logic [PIPE-1:0]  win_pipe_q, win_pipe_d;
    logic [PIPE-1:0]  org_pipe_q, org_pipe_d;
    logic [7:0]       pix_q, pix_d;

    logic h_wrap, visible, hs_act, vs_act, in_win, origin;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end

        visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        // Sync pulses are pipelined as active-high "in pulse" bits so a
        // cleared pipeline stage reads as an inactive (high) sync.
        hs_act  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs_act  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        in_win  = (h_cnt_q >= X_BEG) && (h_cnt_q < X_END) &&
                  (v_cnt_q >= Y_BEG) && (v_cnt_q < Y_END);
        origin  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

        // The offset restarts at the frame origin; the clear takes effect in
        // the same cycle so a window touching (0,0) still starts at 0.
        off_cur  = origin ? '0 : offset_q;
        offset_d = off_cur;
        addr_d   = ADDR_BASE;
        if (in_win) begin
            addr_d = ADDR_BASE + 32'(off_cur);
            if (off_cur != OFF_LAST) begin
                offset_d = off_cur + OFF_W'(1);
            end
        end

        hs_pipe_d  = {hs_pipe_q[PIPE-2:0], hs_act};
        vs_pipe_d  = {vs_pipe_q[PIPE-2:0], vs_act};
        vis_pipe_d = {vis_pipe_q[PIPE-2:0], visible};
        win_pipe_d = {win_pipe_q[PIPE-2:0], in_win};
        org_pipe_d = {org_pipe_q[PIPE-2:0], origin};

        // Stage PIPE-2 lines up with the cycle vram_out holds this pixel.
        pix_d = (win_pipe_q[PIPE-2] && enable) ? vram.vram_out : 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            offset_q   <= '0;
            addr_q     <= '0;
            hs_pipe_q  <= '0;
            vs_pipe_q  <= '0;
            vis_pipe_q <= '0;
            win_pipe_q <= '0;
            org_pipe_q <= '0;
            pix_q      <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            offset_q   <= offset_d;
            addr_q     <= addr_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            vis_pipe_q <= vis_pipe_d;
            win_pipe_q <= win_pipe_d;
            org_pipe_q <= org_pipe_d;
            pix_q      <= pix_d;
        end
    end

    assign vram.gpu_address = addr_q;
    assign hsync            = ~hs_pipe_q[PIPE-1];
    assign vsync            = ~vs_pipe_q[PIPE-1];
    assign blank_n          = vis_pipe_q[PIPE-1];
    assign frame_start      = org_pipe_q[PIPE-1];
    assign sync_n           = 1'b0;
    assign r                = pix_q;
    assign g                = pix_q;
    assign b                = pix_q;
endmodule
